div: RTL and testbench
======================

// Module: div
// PURPOSE
//  Sequential 32-bit integer divider (restoring shift-subtract, one quotient bit per clock).
//  Used by the TL45 ALU stage for DIV (signed) and UDIV (unsigned).
//  The ALU raises i_wr for one cycle with operands, then stalls the pipe until o_valid pulses.
//  Returns the quotient only; the remainder is internal and not exported.
// PARAMETERS
//  BW    32  operand/quotient width in bits
//  LGBW   5  log2(BW); width of the iteration counter
// PORTS
//  i_clk          in   1   clock, all state updates on rising edge
//  i_reset        in   1   reset, synchronous, active-high
//  i_wr           in   1   start request; operands sampled on the same edge
//  i_signed       in   1   1 = two's-complement divide, 0 = unsigned
//  i_numerator    in   BW  dividend
//  i_denominator  in   BW  divisor
//  o_busy         out  1   division in progress; new i_wr ignored
//  o_valid        out  1   one-cycle pulse; o_quotient/o_err valid this cycle
//  o_err          out  1   divide-by-zero flag, qualified by o_valid
//  o_quotient     out  BW  result; held until the next accepted start
// BEHAVIOUR
//  - Reset (sync): o_busy=0, o_valid=0, o_err=0, o_quotient=0, counter=0.
//    Aborts any division in progress; no o_valid is produced for the aborted op.
//  - Start acceptance: i_wr && !o_busy && !i_reset at edge E.
//    i_wr while o_busy=1 is ignored and does not disturb the running op.
//  - Divide by zero (i_denominator==0): after E, o_valid=1, o_err=1, o_busy=0, o_quotient=0. Latency 1.
//  - Normal path, after edge E:
//    o_busy=1, o_err=0, o_valid=0.
//    Latch |num| and |den|; negate an operand only if i_signed and its MSB=1.
//    Latch the result-sign flag = i_signed & (num[31]^den[31]).
//  - Edges E+1..E+32: one restoring step per edge, MSB first.
//    Form {rem,num} shifted left by 1; if rem >= den then rem-=den and the quotient bit is 1.
//    The comparison is BW+1 bits wide so no carry is lost.
//  - Edge E+33: apply the sign: quotient = flag ? -q : q.
//    After E+33, o_valid=1, o_busy=0, o_quotient=final value.
//  - After E+34: o_valid=0 and o_quotient holds.
//    o_valid is high for exactly one cycle. Total latency: 33 edges after the accepting edge.
//  - A start accepted in the same cycle o_valid is high is legal; o_valid drops on the next edge.
//  - Unsigned: truncating quotient, full 0..2^32-1 range.
//  - Signed: truncates toward zero; the remainder sign follows the dividend (internal only).
//  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000 (wraps), o_err=0.
//  - |0x80000000| is computed as unsigned 0x80000000 (correct magnitude in BW bits).
// STRUCTURE
//  - Shared package tl45_pkg: localparam TL45_XLEN=32 and divider latency constant DIV_LATENCY=33.
//  - No sub-module.
//  - Single always_ff block plus combinational trial-subtract.
//  - State is implicit: IDLE (busy=0), ITER (busy=1, counter 31..0), FIX (sign-fix cycle).
// TESTING
//  - Unsigned 100/7, i_wr one cycle -> o_busy high 33 cycles; o_valid pulse at E+33;
//    o_quotient=14, o_err=0.
//  - Signed -100/7 (0xFFFFFF9C/7) -> 0xFFFFFFF2.
//    Signed 100/-7 -> 0xFFFFFFF2.
//    Signed -100/-7 -> 14.
//  - Unsigned 0xFFFFFFFF/1 -> 0xFFFFFFFF.
//    Signed 0x80000000/0xFFFFFFFF -> 0x80000000, o_err=0.
//  - Divide by zero, num=5, den=0 -> next cycle o_valid=1, o_err=1, o_quotient=0, o_busy=0.
//  - Start 1000/10, then pulse i_wr with 9/3 at E+5 -> second request ignored; result 100 at E+33.
//  - Start 1000/10, assert i_reset at E+10 -> all outputs 0 next cycle; no o_valid for the aborted op.
//    A subsequent start works normally.

Source files
------------

// File: rtl/tl45_pkg.sv
// tl45_pkg: shared TL45 constants (datapath width, divider latency)
package tl45_pkg;
  localparam int TL45_XLEN   = 32;
  localparam int DIV_LATENCY = 33;
endpackage

// File: rtl/div.sv
// div: sequential restoring divider, one quotient bit per clock, signed/unsigned, quotient only
// Ports: i_clk, i_reset (sync, active-high), i_wr start strobe with i_signed/i_numerator/i_denominator;
//        o_busy while dividing, o_valid one-cycle result pulse, o_err divide-by-zero, o_quotient held result
module div
  import tl45_pkg::*;
#(
  parameter int BW   = TL45_XLEN,
  parameter int LGBW = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic          i_signed,
  input  logic [BW-1:0] i_numerator,
  input  logic [BW-1:0] i_denominator,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_err,
  output logic [BW-1:0] o_quotient
);
  logic            r_fix, r_sign;
  logic [LGBW-1:0] r_cnt;
  logic [BW-1:0]   r_rem, r_num, r_den;
  logic [BW:0]     w_trial;
  logic            w_ge;
  logic [BW-1:0]   w_diff;
  // r_num doubles as the quotient: dividend bits shift out the top as quotient bits shift in
  assign w_trial = {r_rem, r_num[BW-1]};
  assign w_ge    = w_trial >= {1'b0, r_den};
  // when w_ge the difference is below r_den, so the low BW bits are exact
  assign w_diff  = w_trial[BW-1:0] - r_den;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_quotient <= '0;
      r_cnt      <= '0;
      r_fix      <= 1'b0;
      r_sign     <= 1'b0;
      r_rem      <= '0;
      r_num      <= '0;
      r_den      <= '0;
    end else begin
      o_valid <= 1'b0;
      if (r_fix) begin
        o_quotient <= r_sign ? -r_num : r_num;
        o_valid    <= 1'b1;
        o_busy     <= 1'b0;
        r_fix      <= 1'b0;
      end else if (o_busy) begin
        r_rem <= w_ge ? w_diff : w_trial[BW-1:0];
        r_num <= {r_num[BW-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        r_fix <= r_cnt == '0;
      end else if (i_wr) begin
        if (i_denominator == '0) begin
          o_valid    <= 1'b1;
          o_err      <= 1'b1;
          o_quotient <= '0;
        end else begin
          o_busy <= 1'b1;
          o_err  <= 1'b0;
          r_cnt  <= LGBW'(BW - 1);
          r_rem  <= '0;
          r_num  <= (i_signed && i_numerator[BW-1]) ? -i_numerator : i_numerator;
          r_den  <= (i_signed && i_denominator[BW-1]) ? -i_denominator : i_denominator;
          r_sign <= i_signed & (i_numerator[BW-1] ^ i_denominator[BW-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: randomized scoreboard bench for div against an arithmetic reference model
module tb_div;
  import tl45_pkg::*;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, wr, sgn;
  logic [31:0] num, den;
  logic busy, valid, err;
  logic [31:0] q;
  typedef struct { logic [31:0] q; logic e; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  div dut (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_signed(sgn),
    .i_numerator(num), .i_denominator(den),
    .o_busy(busy), .o_valid(valid), .o_err(err), .o_quotient(q)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic s, input logic [31:0] n, input logic [31:0] d);
    exp_t r;
    longint a, b;
    r.e = d == 0;
    r.q = 0;
    if (d != 0) begin
      if (s) begin
        a = longint'($signed(n));
        b = longint'($signed(d));
        r.q = 32'(a / b);
      end else r.q = n / d;
    end
    return r;
  endfunction
  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", q, e.q);
        chk("err", err, e.e);
        chk("busy_at_valid", busy, 0);
      end
    end
  end
  // caller sits at a negedge; inject_at issues an ignored 9/3 request, abort_at pulses reset
  task automatic run_op(input logic s, input logic [31:0] n, input logic [31:0] d,
                        input int inject_at = 0, input int abort_at = 0);
    bit seen = 0;
    int lat = 0;
    if (abort_at == 0) sb.push_back(model(s, n, d));
    wr = 1; sgn = s; num = n; den = d;
    for (int i = 1; i <= 40 && (!seen || abort_at != 0); i++) begin
      @(negedge clk);
      wr = 0;
      if (i == 1) chk("busy_after_start", busy, d != 0);
      if (abort_at != 0 && i == abort_at + 1) begin
        chk("abort_outputs", {busy, valid, err, q}, 0);
        rst = 0;
      end
      if (valid && !seen) begin seen = 1; lat = i; end
      if (i == inject_at) begin wr = 1; sgn = 0; num = 9; den = 3; end
      if (abort_at != 0 && i == abort_at) rst = 1;
    end
    if (abort_at != 0) chk("no_valid_after_abort", seen, 0);
    else if (!seen) chk("timeout", 0, 1);
    else chk("latency", lat, d == 0 ? 1 : DIV_LATENCY + 1);
  endtask
  initial begin
    rst = 1; wr = 0; sgn = 0; num = 0; den = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, valid, err, q}, 0);
    rst = 0;
    @(negedge clk);
    run_op(0, 100, 7);
    run_op(1, 32'hFFFFFF9C, 7);
    run_op(1, 100, 32'hFFFFFFF9);
    run_op(1, 32'hFFFFFF9C, 32'hFFFFFFF9);
    run_op(0, 32'hFFFFFFFF, 1);
    run_op(1, 32'h80000000, 32'hFFFFFFFF);
    run_op(0, 5, 0);
    run_op(0, 32'h80000000, 32'h80000000);
    run_op(0, 1000, 10, 5);
    @(negedge clk);
    run_op(0, 1000, 10, 0, 10);
    run_op(0, 1000, 10);
    run_op(1, 7, 0);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] n, d;
      n = $urandom;
      d = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1 && sb.size() == 0) @(negedge clk);
      run_op(1'($urandom_range(0, 1)), n, d);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
